btn_event_arbiter: RTL
======================

// Module: btn_event_arbiter
// PURPOSE
//  Collects single-cycle button events from N debounced/one-pulsed switch inputs and
//  serializes them, round-robin, to one consumer (e.g. the Bluetooth UART TX framer) over
//  a valid/ready handshake. Holds one pending event per button, so a stalled consumer
//  loses nothing until a button repeats. Counts lost events.
//  Sits between the per-button switch_pulse instances and the command/TX path.
// PARAMETERS
//  N_BTN   4   number of button pulse inputs (2..16)
//  IDW     2   width of evt_id; 2**IDW >= N_BTN required
//  DCW     8   width of drop counter (saturating)
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst_n      in   1      asynchronous active-low reset
//  btn_pulse  in   N_BTN  one-cycle event pulses; bit i = button i
//  evt_valid  out  1      event available on evt_id
//  evt_id     out  IDW    index of button whose event is presented
//  evt_ready  in   1      consumer accepts event when evt_valid & evt_ready
//  pending    out  N_BTN  registered per-button pending flags (status)
//  drop_cnt   out  DCW    number of lost events, saturates at all-ones
//  clr_drop   in   1      synchronous clear of drop_cnt
// BEHAVIOUR
//  Reset (rst_n=0, takes effect immediately, no clock needed): evt_valid=0, evt_id=0,
//   pending=0, drop_cnt=0, RR pointer last=N_BTN-1 (button 0 has first priority).
//  Pending: on each posedge, pending[i] <= (pending[i] & ~grant[i]) | btn_pulse[i].
//   A pulse on i in the cycle i is granted re-sets pending[i] (new event, not a drop).
//  Drop: btn_pulse[i] & pending[i] & ~grant[i] = one lost event. drop_cnt adds the
//   number of such bits in the cycle (0..N_BTN), saturating at 2**DCW-1.
//   clr_drop has priority: drop_cnt <= 0 that cycle; coincident drops are not counted.
//  Output slot: free = ~evt_valid | evt_ready. If free and pending!=0, grant the first
//   set bit searching last+1, last+2, ... (mod N_BTN); on that edge evt_id <= index,
//   evt_valid <= 1, pending[index] cleared, last <= index.
//   If free and pending==0: evt_valid <= 0 (evt_id holds its last value).
//  FSM (implied by evt_valid): EMPTY (valid=0) -> FULL on grant; FULL stays while
//   ~evt_ready; FULL -> FULL with next id on handshake when pending!=0
//   (back-to-back, 1 event/cycle); FULL -> EMPTY on handshake when pending==0.
//  Handshake rules: while evt_valid & ~evt_ready, evt_id and evt_valid are stable;
//   evt_valid never depends combinationally on evt_ready.
//  Latency: btn_pulse high before edge k -> pending set at k -> evt_valid high after
//   edge k+1 (output slot free). Events do not bypass pending.
//  A btn_pulse held high for M cycles is M events; the input contract is 1-cycle pulses.
//  Grant uses only registered pending, never same-cycle btn_pulse.
// TESTING
//  1 Reset, evt_ready=1, pulse btn_pulse=4'b0100 one cycle at edge k -> evt_valid=1,
//    evt_id=2 for exactly the cycle after edge k+1; pending back to 0; drop_cnt=0.
//  2 Reset, evt_ready=1, btn_pulse=4'b1111 one cycle -> ids 0,1,2,3 on four
//    consecutive cycles, evt_valid continuous, then 0.
//  3 evt_ready=0, pulse btn1 three separate times -> evt_id=1 held stable, pending=4'b0010,
//    drop_cnt=1; raise evt_ready -> id 1 accepted, id 1 again next cycle, then valid=0.
//  4 RR: after a grant of id 2, load pending=4'b1001 under backpressure, release ready
//    -> order 3 then 0.
//  5 Hold ready=0, pending[0] set, pulse btn0 300 times -> drop_cnt=255 (saturated);
//    clr_drop with a coincident drop -> drop_cnt=0.
//  6 Assert rst_n=0 mid-cycle while evt_valid=1 -> evt_valid, pending, drop_cnt go 0
//    before the next clk edge; after release, button 0 wins first arbitration.

Source files
------------

// File: rtl/btn_event_if.sv
// Button-event bus between the arbiter and its producer/consumer side.
// The slave modport is the arbiter; the master modport drives pulses and ready.
interface btn_event_if #(
  parameter int N_BTN = 4,
  parameter int IDW   = 2,
  parameter int DCW   = 8
);
  logic [N_BTN-1:0] btn_pulse;
  logic             evt_valid;
  logic [IDW-1:0]   evt_id;
  logic             evt_ready;
  logic [N_BTN-1:0] pending;
  logic [DCW-1:0]   drop_cnt;
  logic             clr_drop;

  modport slave (
    input  btn_pulse, evt_ready, clr_drop,
    output evt_valid, evt_id, pending, drop_cnt
  );

  modport master (
    output btn_pulse, evt_ready, clr_drop,
    input  evt_valid, evt_id, pending, drop_cnt
  );
endinterface

// File: rtl/btn_event_arbiter.sv
// Round-robin serializer of per-button one-cycle events onto a valid/ready output,
// holding one pending event per button and counting lost events.

module btn_evt_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  input  logic grant,
  output logic pend,
  output logic drop
);
  // A pulse landing on the granted cycle is a fresh event, not a loss.
  assign drop = pulse & pend & ~grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= (pend & ~grant) | pulse;
  end
endmodule

module btn_event_arbiter #(
  parameter int N_BTN = 4,
  parameter int IDW   = 2,
  parameter int DCW   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  btn_event_if.slave  bus
);
  localparam int SW = $clog2(N_BTN + 1);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state;
  logic [IDW-1:0]   evt_id;
  logic [IDW-1:0]   last;
  logic [DCW-1:0]   drop_cnt;
  logic [N_BTN-1:0] pend, drop, grant;
  logic             free, found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW:0]     j;
  logic [SW-1:0]    n_drop;
  logic [DCW+SW-1:0] tot;

  assign bus.evt_valid = (state == ST_FULL);
  assign bus.evt_id    = evt_id;
  assign bus.pending   = pend;
  assign bus.drop_cnt  = drop_cnt;
  assign free          = (state == ST_EMPTY) | bus.evt_ready;

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    btn_evt_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .pulse (bus.btn_pulse[i]),
      .grant (grant[i]),
      .pend  (pend[i]),
      .drop  (drop[i])
    );
  end

  // Search last+1, last+2, ... wrapping at N_BTN; first pending bit wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    j       = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      j = {1'b0, last} + (IDW+1)'(k);
      if (j >= (IDW+1)'(N_BTN)) j = j - (IDW+1)'(N_BTN);
      if (!found && pend[j[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = j[IDW-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (free && found) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_BTN; i++) n_drop = n_drop + SW'(drop[i]);
    tot = (DCW+SW)'(drop_cnt) + (DCW+SW)'(n_drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      evt_id <= '0;
      last   <= IDW'(N_BTN - 1);
    end else if (free) begin
      if (found) begin
        state  <= ST_FULL;
        evt_id <= gnt_idx;
        last   <= gnt_idx;
      end else begin
        state  <= ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              drop_cnt <= '0;
    else if (bus.clr_drop)                   drop_cnt <= '0;
    else if (tot > (DCW+SW)'({DCW{1'b1}}))   drop_cnt <= '1;
    else                                     drop_cnt <= tot[DCW-1:0];
  end
endmodule
